// File: rtl/proto_pkg.sv
// proto_pkg: shared proto245 framing constants, command/response codes and TX FSM states
package proto_pkg;
   localparam logic [7:0]  CMD_PREFIX     = 8'hAA;
   localparam logic [7:0]  CMD_SUFFIX     = 8'h55;
   localparam int          FRAME_BYTES    = 8;
   localparam logic [15:0] CODE_PHASE     = 16'h0001;
   localparam logic [15:0] CODE_BURST     = 16'h0002;
   localparam logic [15:0] CODE_CALIB     = 16'h0003;
   localparam logic [15:0] CODE_DEBUG_LED = 16'h1ED0;
   localparam logic [15:0] RESP_ACK       = 16'h8001;
   typedef enum logic [1:0] {IDLE, WAIT_SPACE, SEND} tx_state_t;
endpackage

// File: rtl/frame_transmitter.sv
// frame_transmitter: writes one 8-byte AA/code/data/55 frame per request into the proto245 TX FIFO
module frame_transmitter
   import proto_pkg::*;
#(
   parameter int TX_FIFO_LOAD_W = 11,
   parameter int TX_FIFO_DEPTH  = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      tx_valid,
   output logic                      tx_ready,
   input  logic [15:0]               tx_code,
   input  logic [31:0]               tx_data,
   output logic                      busy,
   output logic [15:0]               frames_sent,
   input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
   input  logic                      txfifo_full,
   output logic                      txfifo_wr,
   output logic [7:0]                txfifo_data
);
   localparam logic [TX_FIFO_LOAD_W:0] DEPTH = (TX_FIFO_LOAD_W+1)'(TX_FIFO_DEPTH);
   localparam logic [TX_FIFO_LOAD_W:0] NEED  = (TX_FIFO_LOAD_W+1)'(FRAME_BYTES);
   tx_state_t state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [63:0] frame_q, frame_d;
   logic        wr_q, wr_d;
   logic [7:0]  data_q, data_d;
   logic [15:0] sent_q, sent_d;
   logic [TX_FIFO_LOAD_W:0] load_ext, free;
   logic [2:0]  idx_nx;
   logic        written;
   assign load_ext    = {1'b0, txfifo_load};
   assign free        = (load_ext > DEPTH) ? '0 : DEPTH - load_ext;
   assign written     = wr_q & ~txfifo_full;
   assign idx_nx      = idx_q + 3'd1;
   assign tx_ready    = (state_q == IDLE) & ~rst;
   assign busy        = state_q != IDLE;
   assign frames_sent = sent_q;
   assign txfifo_wr   = wr_q;
   assign txfifo_data = data_q;
   // next state: latch request, wait for a whole frame of space, then stream bytes LSB first
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      frame_d = frame_q;
      wr_d    = wr_q;
      data_d  = data_q;
      sent_d  = sent_q;
      case (state_q)
         IDLE: if (tx_valid) begin
            frame_d = {CMD_PREFIX, tx_code, tx_data, CMD_SUFFIX};
            idx_d   = '0;
            state_d = WAIT_SPACE;
         end
         WAIT_SPACE: if (free >= NEED) begin
            wr_d    = 1'b1;
            data_d  = frame_q[7:0];
            state_d = SEND;
         end
         SEND: if (written) begin
            if (idx_q != 3'd7) begin
               idx_d  = idx_nx;
               data_d = frame_q[{idx_nx, 3'b000} +: 8];
            end else begin
               wr_d    = 1'b0;
               sent_d  = sent_q + 16'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         frame_q <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
         sent_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
         sent_q  <= sent_d;
      end
   end
endmodule

// File: tb/tb_frame_transmitter.sv
// tb_frame_transmitter: scoreboard bench for frame_transmitter framing, timing and flow control
module tb_frame_transmitter;
   import proto_pkg::*;
   logic        clk = 1'b0, rst = 1'b1, tx_valid = 1'b0;
   logic [15:0] tx_code = '0;
   logic [31:0] tx_data = '0;
   logic        tx_ready, busy, txfifo_wr;
   logic [15:0] frames_sent;
   logic [10:0] txfifo_load = '0;
   logic        txfifo_full = 1'b0;
   logic [7:0]  txfifo_data;
   int checks = 0, errors = 0;
   logic [7:0] exp_q[$];

   frame_transmitter dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_code(tx_code), .tx_data(tx_data), .busy(busy), .frames_sent(frames_sent),
      .txfifo_load(txfifo_load), .txfifo_full(txfifo_full),
      .txfifo_wr(txfifo_wr), .txfifo_data(txfifo_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [15:0] c, input logic [31:0] d);
      exp_q.push_back(8'h55);
      exp_q.push_back(d[7:0]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[31:24]);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
      exp_q.push_back(8'hAA);
   endtask

   task automatic send_req(input logic [15:0] c, input logic [31:0] d);
      int n;
      n = 0;
      while (!tx_ready && n < 50) begin
         tick();
         n++;
      end
      chk("req_ready", tx_ready, 1);
      tx_valid = 1'b1;
      tx_code  = c;
      tx_data  = d;
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   // a byte presented with wr=1 and full=0 at the negedge is written at the next posedge
   always @(negedge clk) begin
      if (!rst && txfifo_wr && !txfifo_full) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %0h expected none", txfifo_data);
         end else chk("wire_byte", txfifo_data, exp_q.pop_front());
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] t1[8];
      int nwr, acc, c1, c2, bad;
      logic r;
      t1 = '{8'h55, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'hAA};
      repeat (3) tick();
      chk("rst_wr", txfifo_wr, 0);
      chk("rst_data", txfifo_data, 0);
      chk("rst_sent", frames_sent, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", tx_ready, 0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", tx_ready, 1);
      // single frame and its latency
      foreach (t1[i]) exp_q.push_back(t1[i]);
      send_req(CODE_PHASE, 32'hDEADBEEF);
      chk("t1_c1_wr", txfifo_wr, 0);
      tick();
      chk("t1_c2_wr", txfifo_wr, 1);
      chk("t1_c2_data", txfifo_data, 8'h55);
      for (int i = 0; i < 7; i++) begin
         chk("t1_ready_low", tx_ready, 0);
         tick();
      end
      chk("t1_c9_wr", txfifo_wr, 1);
      chk("t1_c9_ready", tx_ready, 0);
      tick();
      chk("t1_c10_ready", tx_ready, 1);
      chk("t1_c10_wr", txfifo_wr, 0);
      chk("t1_sent", frames_sent, 1);
      chk("t1_drained", exp_q.size(), 0);
      // backpressure on byte index 3
      push_frame(CODE_BURST, 32'hDEADBEEF);
      send_req(CODE_BURST, 32'hDEADBEEF);
      repeat (4) tick();
      chk("t2_idx3", txfifo_data, 8'hAD);
      txfifo_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_hold_wr", txfifo_wr, 1);
         chk("t2_hold_data", txfifo_data, 8'hAD);
      end
      txfifo_full = 1'b0;
      wait_idle();
      chk("t2_sent", frames_sent, 2);
      chk("t2_drained", exp_q.size(), 0);
      // free-space gate, full ignored while waiting
      txfifo_load = 11'd1017;
      push_frame(CODE_CALIB, 32'h0BADF00D);
      send_req(CODE_CALIB, 32'h0BADF00D);
      nwr = 0;
      for (int i = 0; i < 20; i++) begin
         txfifo_full = (i < 10);
         if (txfifo_wr) nwr++;
         tick();
      end
      txfifo_full = 1'b0;
      chk("t3_gate_wr", nwr, 0);
      chk("t3_busy", busy, 1);
      txfifo_load = 11'd1016;
      tick();
      chk("t3_open_wr", txfifo_wr, 1);
      chk("t3_open_data", txfifo_data, 8'h55);
      txfifo_load = '0;
      wait_idle();
      chk("t3_sent", frames_sent, 3);
      chk("t3_drained", exp_q.size(), 0);
      // back-to-back with tx_valid held
      push_frame(RESP_ACK, 32'd1);
      tx_valid = 1'b1;
      tx_code  = RESP_ACK;
      tx_data  = 32'd1;
      acc = 0; c1 = 0; c2 = 0; bad = 0;
      for (int cyc = 0; cyc < 60 && acc < 2; cyc++) begin
         r = tx_ready;
         if (busy && tx_ready) bad++;
         tick();
         if (r) begin
            acc++;
            if (acc == 1) begin
               c1 = cyc;
               tx_data = 32'd2;
               push_frame(RESP_ACK, 32'd2);
            end else begin
               c2 = cyc;
               tx_valid = 1'b0;
            end
         end
      end
      for (int n = 0; n < 40 && busy; n++) begin
         if (tx_ready) bad++;
         tick();
      end
      chk("t4_accepts", acc, 2);
      chk("t4_spacing", c2 - c1, 10);
      chk("t4_ready_while_busy", bad, 0);
      chk("t4_idle", busy, 0);
      chk("t4_sent", frames_sent, 5);
      chk("t4_drained", exp_q.size(), 0);
      // reset after four bytes written
      push_frame(RESP_ACK, 32'hCAFEF00D);
      send_req(RESP_ACK, 32'hCAFEF00D);
      repeat (5) tick();
      chk("t5_written", exp_q.size(), 4);
      rst = 1'b1;
      exp_q.delete();
      tick();
      chk("t5_rst_wr", txfifo_wr, 0);
      chk("t5_rst_sent", frames_sent, 0);
      chk("t5_rst_ready", tx_ready, 0);
      chk("t5_rst_busy", busy, 0);
      rst = 1'b0;
      tick();
      chk("t5_ready", tx_ready, 1);
      push_frame(CODE_DEBUG_LED, 32'h00000001);
      send_req(CODE_DEBUG_LED, 32'h00000001);
      tick();
      chk("t5_first_wr", txfifo_wr, 1);
      chk("t5_first_byte", txfifo_data, 8'h55);
      wait_idle();
      chk("t5_sent", frames_sent, 1);
      chk("t5_drained", exp_q.size(), 0);
      // frames_sent wraps
      force dut.sent_q = 16'hFFFF;
      tick();
      tick();
      release dut.sent_q;
      chk("t6_preload", frames_sent, 16'hFFFF);
      push_frame(RESP_ACK, 32'h12345678);
      send_req(RESP_ACK, 32'h12345678);
      wait_idle();
      chk("t6_wrap", frames_sent, 0);
      chk("t6_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
